// File: rtl/fp_wb_arbiter_if.sv
// Writeback, scoreboard and hazard bus of fp_wb_arbiter.
// FPWB_BYPASS_EN adds the register-file forwarding signals.
interface fp_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 64
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_grant;
    logic               iss_valid;
    logic [AW-1:0]      iss_addr;
    logic [AW-1:0]      R_Addr;
    logic [AW-1:0]      S_Addr;
    logic               R_busy;
    logic               S_busy;
    logic               W_En;
    logic [AW-1:0]      W_Addr;
    logic [DW-1:0]      WR;
    logic [31:0]        busy_vec;
`ifdef FPWB_BYPASS_EN
    logic [DW-1:0]      rf_R;
    logic [DW-1:0]      rf_S;
    logic [DW-1:0]      R_fwd;
    logic [DW-1:0]      S_fwd;
`endif

    modport slave (
        input  req_valid, req_addr, req_data,
        input  iss_valid, iss_addr, R_Addr, S_Addr,
`ifdef FPWB_BYPASS_EN
        input  rf_R, rf_S,
        output R_fwd, S_fwd,
`endif
        output req_grant, R_busy, S_busy,
        output W_En, W_Addr, WR, busy_vec
    );

    modport master (
        output req_valid, req_addr, req_data,
        output iss_valid, iss_addr, R_Addr, S_Addr,
`ifdef FPWB_BYPASS_EN
        output rf_R, rf_S,
        input  R_fwd, S_fwd,
`endif
        input  req_grant, R_busy, S_busy,
        input  W_En, W_Addr, WR, busy_vec
    );
endinterface

// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback: round-robin arbiter, registered write
// port, pending-write scoreboard and RAW hazard flags.
// Optional read forwarding is enabled with FPWB_BYPASS_EN.
module fp_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 64
) (
    input logic             clk,
    input logic             rst_n,
    fp_wb_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            w_en_q, w_en_d;
    logic [AW-1:0]   w_addr_q, w_addr_d;
    logic [DW-1:0]   wr_q, wr_d;
    logic [31:0]     busy_q, busy_d;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            found;
    int              idx;

    // Round-robin search from the pointer; reset masks every grant
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
        if (!rst_n) begin
            grant = '0;
            found = 1'b0;
        end
    end

    // Next pointer, write stage and scoreboard; a set beats a clear
    always_comb begin
        ptr_d    = ptr_q;
        w_en_d   = found;
        w_addr_d = w_addr_q;
        wr_d     = wr_q;
        busy_d   = busy_q;
        if (found) begin
            ptr_d    = (gidx == PW'(NREQ - 1)) ? '0 : PW'(gidx + 1'b1);
            w_addr_d = bus.req_addr[int'(gidx)*AW +: AW];
            wr_d     = bus.req_data[int'(gidx)*DW +: DW];
        end
        if (w_en_q) busy_d[w_addr_q] = 1'b0;
        if (bus.iss_valid) busy_d[bus.iss_addr] = 1'b1;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            wr_q     <= '0;
            busy_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.req_grant = grant;
    assign bus.W_En      = w_en_q;
    assign bus.W_Addr    = w_addr_q;
    assign bus.WR        = wr_q;
    assign bus.busy_vec  = busy_q;

`ifdef FPWB_BYPASS_EN
    logic r_hit, s_hit, r_set, s_set;

    assign r_hit = w_en_q && (w_addr_q == bus.R_Addr);
    assign s_hit = w_en_q && (w_addr_q == bus.S_Addr);
    assign r_set = bus.iss_valid && (bus.iss_addr == bus.R_Addr);
    assign s_set = bus.iss_valid && (bus.iss_addr == bus.S_Addr);

    assign bus.R_fwd  = r_hit ? wr_q : bus.rf_R;
    assign bus.S_fwd  = s_hit ? wr_q : bus.rf_S;
    assign bus.R_busy = busy_q[bus.R_Addr] & ~(r_hit & ~r_set);
    assign bus.S_busy = busy_q[bus.S_Addr] & ~(s_hit & ~s_set);
`else
    assign bus.R_busy = busy_q[bus.R_Addr];
    assign bus.S_busy = busy_q[bus.S_Addr];
`endif
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: vector table, directed corner sequences
// and randomized traffic against a behavioural reference model.
module tb_fp_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 64;

    bit   clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fp_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    fp_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // register file written from the DUT write port
    logic [DW-1:0] dut_rf [32];
    always @(posedge clk)
        if (rst_n && bus.W_En) dut_rf[bus.W_Addr] <= bus.WR;

    // reference model state
    int            m_ptr = 0;
    logic [31:0]   m_busy = '0;
    logic          m_wen = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wr = '0;
    logic [DW-1:0] m_rf [32];

    function automatic int m_grant();
        if (!rst_n) return -1;
        for (int k = 0; k < NREQ; k++)
            if (bus.req_valid[(m_ptr + k) % NREQ])
                return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_gvec();
        int g;
        g = m_grant();
        if (g < 0) return '0;
        return NREQ'(1 << g);
    endfunction

    function automatic logic m_hz(input logic [AW-1:0] a);
        logic b;
        b = m_busy[a];
`ifdef FPWB_BYPASS_EN
        if (m_wen && m_waddr == a && !(bus.iss_valid && bus.iss_addr == a))
            b = 1'b0;
`endif
        return b;
    endfunction

    task automatic m_edge();
        int g;
        g = m_grant();
        if (rst_n && m_wen) m_rf[m_waddr] = m_wr;
        if (!rst_n) begin
            m_ptr = 0; m_busy = '0; m_wen = 1'b0;
            m_waddr = '0; m_wr = '0;
        end else begin
            if (m_wen) m_busy[m_waddr] = 1'b0;
            if (bus.iss_valid) m_busy[bus.iss_addr] = 1'b1;
            m_wen = (g >= 0);
            if (g >= 0) begin
                m_waddr = bus.req_addr[g*AW +: AW];
                m_wr    = bus.req_data[g*DW +: DW];
                m_ptr   = (g + 1) % NREQ;
            end
        end
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int u, input logic v,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[u]         = v;
        bus.req_addr[u*AW +: AW] = a;
        bus.req_data[u*DW +: DW] = d;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.iss_valid = 1'b0;
    endtask

    typedef struct {
        logic [NREQ-1:0] vld;
        logic [NREQ-1:0] g;
        logic            wen;
        logic [AW-1:0]   wa;
    } vec_t;

    vec_t tbl [14];

    logic          hv [NREQ];
    logic [AW-1:0] ha [NREQ];
    logic [DW-1:0] hd [NREQ];

    initial begin
        tbl[0]  = '{3'b111, 3'b001, 1'b1, 5'd16};
        tbl[1]  = '{3'b111, 3'b010, 1'b1, 5'd17};
        tbl[2]  = '{3'b111, 3'b100, 1'b1, 5'd18};
        tbl[3]  = '{3'b111, 3'b001, 1'b1, 5'd16};
        tbl[4]  = '{3'b111, 3'b010, 1'b1, 5'd17};
        tbl[5]  = '{3'b111, 3'b100, 1'b1, 5'd18};
        tbl[6]  = '{3'b101, 3'b001, 1'b1, 5'd16};
        tbl[7]  = '{3'b101, 3'b100, 1'b1, 5'd18};
        tbl[8]  = '{3'b101, 3'b001, 1'b1, 5'd16};
        tbl[9]  = '{3'b101, 3'b100, 1'b1, 5'd18};
        tbl[10] = '{3'b010, 3'b010, 1'b1, 5'd17};
        tbl[11] = '{3'b000, 3'b000, 1'b0, 5'd17};
        tbl[12] = '{3'b110, 3'b100, 1'b1, 5'd18};
        tbl[13] = '{3'b011, 3'b001, 1'b1, 5'd16};

        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = '0;
        bus.R_Addr    = '0;
        bus.S_Addr    = '0;
`ifdef FPWB_BYPASS_EN
        bus.rf_R = '0;
        bus.rf_S = '0;
`endif

        // reset with requests present: no grant, outputs cleared
        for (int u = 0; u < NREQ; u++) set_req(u, 1'b1, 5'(u), 64'(u));
        #1;
        chk("rst_grant", 64'(bus.req_grant), 64'h0);
        tick();
        tick();
        chk("rst_wen", 64'(bus.W_En), 64'h0);
        chk("rst_busy", 64'(bus.busy_vec), 64'h0);
        chk("rst_grant2", 64'(bus.req_grant), 64'h0);
        idle();
        rst_n = 1'b1;
        #1;
        chk("idle_grant", 64'(bus.req_grant), 64'h0);
        tick();
        chk("idle_wen", 64'(bus.W_En), 64'h0);
        chk("idle_waddr", 64'(bus.W_Addr), 64'h0);
        chk("idle_wr", bus.WR, 64'h0);
        chk("idle_busy", 64'(bus.busy_vec), 64'h0);

        // single request from unit 1
        set_req(1, 1'b1, 5'd5, 64'h3FF0000000000000);
        #1;
        chk("single_grant", 64'(bus.req_grant), 64'h2);
        tick();
        idle();
        chk("single_wen", 64'(bus.W_En), 64'h1);
        chk("single_waddr", 64'(bus.W_Addr), 64'h5);
        chk("single_wr", bus.WR, 64'h3FF0000000000000);
        tick();
        chk("single_wen_off", 64'(bus.W_En), 64'h0);
        chk("single_hold", 64'(bus.W_Addr), 64'h5);

        // vector table from pointer 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            for (int u = 0; u < NREQ; u++)
                set_req(u, tbl[i].vld[u], 5'(16 + u), 64'h1000 + 64'(u));
            #1;
            chk($sformatf("tbl%0d_grant", i), 64'(bus.req_grant),
                64'(tbl[i].g));
            tick();
            chk($sformatf("tbl%0d_wen", i), 64'(bus.W_En), 64'(tbl[i].wen));
            chk($sformatf("tbl%0d_waddr", i), 64'(bus.W_Addr),
                64'(tbl[i].wa));
            chk($sformatf("tbl%0d_wr", i), bus.WR,
                64'h1000 + 64'(tbl[i].wa) - 64'd16);
        end
        idle();
        tick();

        // scoreboard: set, hazard, clear, set-wins, disjoint set/clear
        bus.R_Addr = 5'd7;
        bus.S_Addr = 5'd8;
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 5'd7;
        #1;
        chk("sb_pending_rbusy", 64'(bus.R_busy), 64'h0);
        tick();
        bus.iss_valid = 1'b0;
        #1;
        chk("sb_set", 64'(bus.busy_vec[7]), 64'h1);
        chk("sb_rbusy", 64'(bus.R_busy), 64'h1);
        chk("sb_sbusy", 64'(bus.S_busy), 64'h0);
        set_req(0, 1'b1, 5'd7, 64'hAAAA);
        tick();
        bus.req_valid = '0;
        chk("sb_wen", 64'(bus.W_En), 64'h1);
        chk("sb_busy_during_wr", 64'(bus.busy_vec[7]), 64'h1);
        tick();
        chk("sb_clear", 64'(bus.busy_vec[7]), 64'h0);
        chk("sb_rbusy_clr", 64'(bus.R_busy), 64'h0);
        bus.iss_valid = 1'b1;
        tick();
        bus.iss_valid = 1'b0;
        set_req(0, 1'b1, 5'd7, 64'hBBBB);
        tick();
        bus.req_valid = '0;
        bus.iss_valid = 1'b1;
        tick();
        bus.iss_valid = 1'b0;
        chk("sb_set_wins", 64'(bus.busy_vec[7]), 64'h1);
        set_req(0, 1'b1, 5'd7, 64'hCCCC);
        tick();
        bus.req_valid = '0;
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 5'd9;
        tick();
        bus.iss_valid = 1'b0;
        chk("sb_both_clr", 64'(bus.busy_vec[7]), 64'h0);
        chk("sb_both_set", 64'(bus.busy_vec[9]), 64'h1);
        tick();

`ifdef FPWB_BYPASS_EN
        set_req(0, 1'b1, 5'd3, 64'hC000000000000000);
        tick();
        bus.req_valid = '0;
        bus.R_Addr = 5'd3;
        bus.S_Addr = 5'd4;
        bus.rf_R = '0;
        bus.rf_S = 64'h1234;
        #1;
        chk("byp_rfwd", bus.R_fwd, 64'hC000000000000000);
        chk("byp_sfwd", bus.S_fwd, 64'h1234);
        tick();
`endif

        // reset mid-operation squashes the registered write
        set_req(2, 1'b1, 5'd12, 64'hDEAD);
        #1;
        chk("mid_grant", 64'(bus.req_grant), 64'h4);
        tick();
        bus.req_valid = '0;
        chk("mid_wen", 64'(bus.W_En), 64'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_wen_squash", 64'(bus.W_En), 64'h0);
        chk("mid_busy", 64'(bus.busy_vec), 64'h0);
        chk("mid_rf12", dut_rf[12], m_rf[12]);
        for (int u = 0; u < NREQ; u++) set_req(u, 1'b1, 5'(u), 64'(u));
        #1;
        chk("mid_ptr0", 64'(bus.req_grant), 64'h1);
        tick();
        idle();
        tick();

        // randomized traffic against the model
        for (int u = 0; u < NREQ; u++) hv[u] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            int gl;
            rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            for (int u = 0; u < NREQ; u++) begin
                if (!hv[u]) begin
                    hv[u] = ($urandom_range(0, 9) < 6);
                    ha[u] = 5'($urandom_range(0, 7));
                    hd[u] = {$urandom, $urandom};
                end
                set_req(u, hv[u], ha[u], hd[u]);
            end
            bus.iss_valid = ($urandom_range(0, 9) < 4);
            bus.iss_addr  = 5'($urandom_range(0, 7));
            bus.R_Addr    = 5'($urandom_range(0, 7));
            bus.S_Addr    = 5'($urandom_range(0, 7));
`ifdef FPWB_BYPASS_EN
            bus.rf_R = {$urandom, $urandom};
            bus.rf_S = {$urandom, $urandom};
`endif
            #1;
            chk("rnd_grant", 64'(bus.req_grant), 64'(m_gvec()));
            chk("rnd_rbusy", 64'(bus.R_busy), 64'(m_hz(bus.R_Addr)));
            chk("rnd_sbusy", 64'(bus.S_busy), 64'(m_hz(bus.S_Addr)));
            chk("rnd_wen", 64'(bus.W_En), 64'(m_wen));
            chk("rnd_waddr", 64'(bus.W_Addr), 64'(m_waddr));
            chk("rnd_wr", bus.WR, m_wr);
            chk("rnd_busy", 64'(bus.busy_vec), 64'(m_busy));
            gl = m_grant();
            tick();
            if (!rst_n)
                for (int u = 0; u < NREQ; u++) hv[u] = 1'b0;
            else if (gl >= 0)
                hv[gl] = 1'b0;
        end
        rst_n = 1'b1;
        idle();
        tick();
        tick();
        for (int a = 0; a < 32; a++)
            chk($sformatf("rf%0d", a), dut_rf[a], m_rf[a]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
